// File: rtl/rv_pkg.sv
// Shared register-file constants and types for the integer pipeline.
// Widths here are the defaults; blocks may override them through parameters.
package rv_pkg;
    localparam int XLEN = 32;
    localparam int RIDX = 5;
    localparam int NREG = 1 << RIDX;

    typedef logic [RIDX-1:0] ridx_t;

    localparam ridx_t X0 = '0;

    // One buffered long-latency completion
    typedef struct packed {
        ridx_t            rd;
        logic [XLEN-1:0]  data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Parameterised synchronous FIFO holding long-latency completions.
// Pointers carry one extra wrap bit so full/empty need no counter.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: empty/full gate every read of it
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= din;
    end

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];
endmodule

// File: rtl/gpr_writeback.sv
// GPR write-port front end: merges pipeline writeback with buffered
// long-latency completions and tracks per-register busy bits for decode.
module gpr_writeback #(
    parameter int DEPTH = 4,
    parameter int XLEN  = rv_pkg::XLEN,
    parameter int RIDX  = rv_pkg::RIDX
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_we,
    input  logic [RIDX-1:0] pipe_rd,
    input  logic [XLEN-1:0] pipe_rrd,
    input  logic            ll_issue,
    input  logic [RIDX-1:0] ll_issue_rd,
    input  logic            ll_valid,
    output logic            ll_ready,
    input  logic [RIDX-1:0] ll_rd,
    input  logic [XLEN-1:0] ll_rrd,
    input  logic [RIDX-1:0] chk_rs1,
    input  logic [RIDX-1:0] chk_rs2,
    input  logic [RIDX-1:0] chk_rd,
    output logic            stall,
    output logic [RIDX-1:0] rd,
    output logic [XLEN-1:0] rrd,
    output logic            we,
    output logic            conflict
);
    localparam int NREG = 1 << RIDX;
    localparam int EW   = RIDX + XLEN;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            conflict_nxt;

    logic            pipe_act;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic [EW-1:0]   head;
    logic [RIDX-1:0] head_rd;
    logic [XLEN-1:0] head_data;

    assign pipe_act = pipe_we && (pipe_rd != '0);

    // ll_ready looks only at full, never at pop, to keep it off the arbitration path
    assign ll_ready = !fifo_full;
    assign push     = ll_valid && ll_ready && (ll_rd != '0);
    assign pop      = !pipe_act && !fifo_empty;

    assign {head_rd, head_data} = head;

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({ll_rd, ll_rrd}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    always_comb begin
        we  = 1'b0;
        rd  = '0;
        rrd = '0;
        if (pipe_act) begin
            we  = 1'b1;
            rd  = pipe_rd;
            rrd = pipe_rrd;
        end else if (!fifo_empty) begin
            we  = 1'b1;
            rd  = head_rd;
            rrd = head_data;
        end
    end

    // Clear before set so a same-cycle issue re-arms the bit
    always_comb begin
        busy_nxt = busy;
        if (pop)      busy_nxt[head_rd]     = 1'b0;
        if (ll_issue) busy_nxt[ll_issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        conflict_nxt = conflict;
        if (pipe_act && busy[pipe_rd]) conflict_nxt = 1'b1;
        if (push && !busy[ll_rd])      conflict_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            conflict <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            conflict <= conflict_nxt;
        end
    end

    assign stall = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd];
endmodule

// File: tb/tb_gpr_writeback.sv
// Randomised and directed bench for gpr_writeback against a queue-based model.
module tb_gpr_writeback;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_rrd;
    logic        ll_issue;
    logic [4:0]  ll_issue_rd;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_rd;
    logic [31:0] ll_rrd;
    logic [4:0]  chk_rs1, chk_rs2, chk_rd;
    logic        stall;
    logic [4:0]  rd;
    logic [31:0] rrd;
    logic        we;
    logic        conflict;

    gpr_writeback #(.DEPTH(DEPTH), .XLEN(32), .RIDX(5)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_rrd(pipe_rrd),
        .ll_issue(ll_issue), .ll_issue_rd(ll_issue_rd),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_rrd(ll_rrd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
        .stall(stall), .rd(rd), .rrd(rrd), .we(we), .conflict(conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t      mq[$];
    bit [31:0] mbusy;
    bit        mconf;
    int        checks   = 0;
    int        failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        rst = 1'b0; pipe_we = 1'b0; pipe_rd = '0; pipe_rrd = '0;
        ll_issue = 1'b0; ll_issue_rd = '0; ll_valid = 1'b0; ll_rd = '0; ll_rrd = '0;
        chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
    endtask

    // Entered at a negedge with inputs set: check outputs, then advance the model
    task automatic step();
        bit          pa, acc;
        bit          ewe;
        logic [4:0]  erd;
        logic [31:0] errd;
        bit [31:0]   nb;
        #1;
        pa = pipe_we && (pipe_rd != 0);
        ewe = 0; erd = 0; errd = 0;
        if (pa) begin
            ewe = 1; erd = pipe_rd; errd = pipe_rrd;
        end else if (mq.size() > 0) begin
            ewe = 1; erd = mq[0].rd; errd = mq[0].data;
        end
        check("we", we, ewe);
        check("rd", rd, erd);
        check("rrd", rrd, errd);
        check("ll_ready", ll_ready, mq.size() < DEPTH);
        check("stall", stall, mbusy[chk_rs1] | mbusy[chk_rs2] | mbusy[chk_rd]);
        check("conflict", conflict, mconf);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mbusy = '0;
            mconf = 0;
        end else begin
            nb  = mbusy;
            acc = ll_valid && (mq.size() < DEPTH) && (ll_rd != 0);
            if (pa && mbusy[pipe_rd]) mconf = 1;
            if (acc && !mbusy[ll_rd]) mconf = 1;
            if (!pa && mq.size() > 0) begin
                nb[mq[0].rd] = 0;
                void'(mq.pop_front());
            end
            if (acc) mq.push_back('{rd: ll_rd, data: ll_rrd});
            if (ll_issue && ll_issue_rd != 0) nb[ll_issue_rd] = 1;
            mbusy = nb;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1;
        step(); step();
        idle();
    endtask

    function automatic bit queued(input logic [4:0] r);
        foreach (mq[i]) if (mq[i].rd == r) return 1;
        return 0;
    endfunction

    initial begin
        bit accepted;
        logic [4:0] cand[$];
        idle(); rst = 1'b1;
        @(posedge clk); @(negedge clk);
        mq.delete(); mbusy = '0; mconf = 0;
        do_reset();

        // Idle check of an unrelated source
        chk_rs1 = 5; step();

        // Issue and complete x7
        idle(); ll_issue = 1; ll_issue_rd = 7; step();
        idle(); chk_rs1 = 7; step();
        ll_valid = 1; ll_rd = 7; ll_rrd = 32'hDEADBEEF; step();
        idle(); chk_rs1 = 7; step();
        step();

        // Pipeline priority over a buffered completion
        idle(); ll_issue = 1; ll_issue_rd = 9; step();
        idle(); ll_valid = 1; ll_rd = 9; ll_rrd = 32'h11; chk_rs2 = 9;
        pipe_we = 1; pipe_rd = 3; pipe_rrd = 32'h22; step();
        ll_valid = 0; step(); step();
        idle(); chk_rs2 = 9; step(); step();

        // Fill the FIFO while the pipeline holds the port
        for (int r = 1; r <= 5; r++) begin
            idle(); ll_issue = 1; ll_issue_rd = 5'(r); step();
        end
        for (int r = 1; r <= 4; r++) begin
            idle(); pipe_we = 1; pipe_rd = 2; pipe_rrd = 32'h200 + r;
            ll_valid = 1; ll_rd = 5'(r); ll_rrd = 32'hA000 + r; step();
        end
        idle(); pipe_we = 1; pipe_rd = 2; pipe_rrd = 32'h2FF;
        ll_valid = 1; ll_rd = 5; ll_rrd = 32'hA005; chk_rd = 5; step(); step();
        pipe_we = 0;
        accepted = 0;
        for (int i = 0; i < 10 && !accepted; i++) begin
            accepted = (mq.size() < DEPTH);
            step();
        end
        check("x5_accept_timeout", accepted, 1'b1);
        idle(); chk_rd = 5;
        for (int i = 0; i < 6; i++) step();

        // x0 handling
        idle(); pipe_we = 1; pipe_rd = 0; pipe_rrd = 32'h55; step();
        idle(); ll_issue = 1; ll_issue_rd = 0; chk_rs1 = 0; step();
        idle(); ll_valid = 1; ll_rd = 0; ll_rrd = 32'h66; step();
        idle(); step(); step();

        // Random traffic, mostly well-formed, with occasional mid-run resets
        do_reset();
        for (int n = 0; n < 400; n++) begin
            idle();
            if ($urandom_range(63) == 0) rst = 1'b1;
            if ($urandom_range(3) != 0) begin
                ll_issue = 1; ll_issue_rd = 5'($urandom_range(31));
            end
            cand.delete();
            for (int r = 1; r < 32; r++) if (mbusy[r] && !queued(5'(r))) cand.push_back(5'(r));
            if ((cand.size() > 0 && $urandom_range(1) == 0) || $urandom_range(31) == 0) begin
                ll_valid = 1;
                ll_rd = (cand.size() > 0) ? cand[$urandom_range(cand.size()-1)] : 5'($urandom_range(31));
                ll_rrd = $urandom;
            end
            if ($urandom_range(2) == 0) begin
                pipe_we = 1; pipe_rd = 5'($urandom_range(31)); pipe_rrd = $urandom;
                if (mbusy[pipe_rd] && $urandom_range(7) != 0) pipe_rd = 0;
            end
            chk_rs1 = 5'($urandom_range(31));
            chk_rs2 = 5'($urandom_range(31));
            chk_rd  = 5'($urandom_range(31));
            step();
        end

        // Same-cycle pop and re-issue of x4, then a pipeline write to busy x4
        do_reset();
        idle(); ll_issue = 1; ll_issue_rd = 4; step();
        idle(); ll_valid = 1; ll_rd = 4; ll_rrd = 32'h44; step();
        idle(); ll_issue = 1; ll_issue_rd = 4; chk_rd = 4; step();
        idle(); chk_rd = 4; step();
        idle(); pipe_we = 1; pipe_rd = 4; pipe_rrd = 32'h77; step();
        idle(); step(); step(); step();
        do_reset();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gpr_writeback.md
Name: gpr_writeback

Overview:
Write-side front end of the 32x32 2R/1W general-purpose register file. It merges the in-order pipeline writeback stream with out-of-order completions from long-latency units (divider, load miss) into the file's single write port (rd/rrd/we). It buffers long-latency results in a small FIFO and keeps a per-register busy scoreboard, so decode can stall on RAW and WAW hazards. It never asserts we for x0.

Parameters:
DEPTH, 4, long-latency completion FIFO entries; power of 2, minimum 2
XLEN, 32, data width
RIDX, 5, register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
pipe_we  in  1  pipeline writeback valid; no backpressure
pipe_rd  in  RIDX  pipeline destination register
pipe_rrd  in  XLEN  pipeline result
ll_issue  in  1  long-latency op issued this cycle
ll_issue_rd  in  RIDX  its destination register
ll_valid  in  1  long-latency completion valid
ll_ready  out  1  FIFO can accept a completion
ll_rd  in  RIDX  completion destination
ll_rrd  in  XLEN  completion data
chk_rs1  in  RIDX  decode source 1 to check
chk_rs2  in  RIDX  decode source 2 to check
chk_rd  in  RIDX  decode destination to check
stall  out  1  hazard against a pending long-latency write
rd  out  RIDX  register-file write index
rrd  out  XLEN  register-file write data
we  out  1  register-file write enable
conflict  out  1  sticky error flag

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - FIFO emptied; busy[31:0]=0; conflict=0.
  - Outputs after reset: ll_ready=1, we=0, stall=0, rd=0, rrd=0.
- Port arbitration (combinational, same cycle):
  - pipe_act = pipe_we && pipe_rd!=0. Pipeline has strict priority.
  - If pipe_act: rd=pipe_rd, rrd=pipe_rrd, we=1.
  - Else if FIFO non-empty: rd/rrd from FIFO head, we=1, head popped at the edge.
  - Else: we=0, rd=0, rrd=0.
  - pipe_we with pipe_rd==0 is dropped silently; the FIFO may drain that cycle.
- FIFO:
  - Push when ll_valid && ll_ready. ll_ready = !full.
  - A completion with ll_rd==0 is accepted (handshake completes) but not pushed.
  - Push and pop in the same cycle are legal when full: ll_ready stays 0 when full. It is not pop-dependent, to avoid a combinational path.
  - Pointers are RIDX-independent, log2(DEPTH)+1 bits, and wrap naturally.
  - Data written to the GPR on the pop cycle; latency from handshake to GPR write is ≥1 cycle (1 when no pipeline write).
- Scoreboard:
  - ll_issue && ll_issue_rd!=0 sets busy[ll_issue_rd] at the edge.
  - A FIFO pop clears busy[popped rd] at the edge.
  - Set and clear of the same index in the same cycle: set wins.
- Hazard (combinational): stall = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd].
  - busy[0] is always 0.
  - No forwarding from the FIFO: stall holds until the cycle after the pop.
- Conflict:
  - conflict set at the edge if pipe_act && busy[pipe_rd], or if a push targets a register whose busy bit is 0.
  - Cleared only by rst.
- Reset mid-operation: buffered completions are discarded with no GPR write. The upstream units are reset together.

Decomposition:
- Shared package `rv_pkg`:
  - XLEN and RIDX constants.
  - Register-index typedef.
  - X0 constant.
- Natural sub-module: `wb_fifo`, a parameterised synchronous FIFO with ports push/pop/full/empty/head. Arbitration and scoreboard stay in gpr_writeback.

Test Plan:
- Reset then idle:
  - rst=1 for 2 cycles -> we=0, ll_ready=1, stall=0, conflict=0.
  - chk_rs1=5 -> stall=0.
- Issue and complete:
  - ll_issue_rd=7, then chk_rs1=7 -> stall=1.
  - ll_valid rd=7 data=0xDEADBEEF with no pipe_we -> next cycle we=1, rd=7, rrd=0xDEADBEEF; the cycle after, stall=0.
- Priority:
  - Busy x9; completion for x9 (0x11) buffered.
  - pipe_we rd=3 data=0x22 held 3 cycles -> we=1, rd=3 for all 3 cycles.
  - Cycle 4 -> rd=9, rrd=0x11.
- Full FIFO:
  - Issue x1..x5; hold pipe_we rd=2; push completions x1..x4 -> ll_ready=0 after the 4th.
  - x5 waits; release pipe_we -> drains x1..x4 in order; then ll_ready=1 and x5 is accepted.
- x0 handling:
  - pipe_we rd=0 -> we=0.
  - ll_issue_rd=0 -> busy unchanged, stall=0 for chk_rs1=0.
  - ll_valid rd=0 -> accepted, no write.
- Conflict and same-cycle set/clear:
  - Pop of x4 in the same cycle as ll_issue_rd=4 -> busy[4]=1 afterwards.
  - pipe_we rd=4 -> conflict=1, sticky until rst.
